// File: rtl/mult_div_unit_if.sv
// Pipeline-to-MDU bundle: E-stage op request in, Busy interlock and HI/LO out.
interface mult_div_unit_if;
    logic        start;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, flush, op, a, b, input busy, hi, lo);
    modport slave  (input start, flush, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; Busy held for MULT_CYCLES/DIV_CYCLES, then commit.
// Optional madd/maddu/msub/msubu accumulate ops are compiled in with `define MDU_MADD_EN.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mult_div_unit_if.slave mdu
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        long_op, div_op;
    logic        sgn, neg_a, neg_b;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] abs_a, abs_b, divisor, uq, ur, quo, rem;
    logic [63:0] res;
    logic        res_ok;

    always_comb begin
        long_op = 1'b0;
        div_op  = 1'b0;
        case (mdu.op)
            OP_MULT, OP_MULTU: long_op = 1'b1;
            OP_DIV, OP_DIVU: begin
                long_op = 1'b1;
                div_op  = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op = 1'b1;
`endif
            default: long_op = 1'b0;
        endcase
    end

    // Result is formed from the latched operands at the commit edge.
    assign sgn     = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign mul_a   = {{32{sgn & a_q[31]}}, a_q};
    assign mul_b   = {{32{sgn & b_q[31]}}, b_q};
    assign product = mul_a * mul_b;

    // Signed divide via magnitudes; INT_MIN / -1 wraps back to INT_MIN naturally.
    assign neg_a   = sgn & a_q[31];
    assign neg_b   = sgn & b_q[31];
    assign abs_a   = neg_a ? (32'd0 - a_q) : a_q;
    assign abs_b   = neg_b ? (32'd0 - b_q) : b_q;
    assign divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign uq      = abs_a / divisor;
    assign ur      = abs_a % divisor;
    assign quo     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    assign rem     = neg_a ? (32'd0 - ur) : ur;

    always_comb begin
        res_ok = 1'b1;
        res    = {hi_q, lo_q};
        case (op_q)
            OP_MULT, OP_MULTU: res = product;
            OP_DIV, OP_DIVU: begin
                if (b_q == 32'd0) res_ok = 1'b0;
                else              res    = {rem, quo};
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res = {hi_q, lo_q} + product;
            OP_MSUB, OP_MSUBU: res = {hi_q, lo_q} - product;
`endif
            default: res_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (mdu.start && !mdu.flush) begin
                    if (long_op) begin
                        state_d = RUN;
                        cnt_d   = div_op ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        op_d    = mdu.op;
                        a_d     = mdu.a;
                        b_d     = mdu.b;
                    end else if (mdu.op == OP_MTHI) begin
                        hi_d = mdu.a;
                    end else if (mdu.op == OP_MTLO) begin
                        lo_d = mdu.a;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (res_ok) {hi_d, lo_d} = res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdu.busy = (state_q == RUN);
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule
